// File: rtl/bcd_seg7_pkg.sv
// -----------------------------------------------------------------------------
// bcd_seg7_pkg
// Shared constants for the BCD to 7-segment display path.
//   - Active-low segment patterns (bit0=a .. bit6=g) for digits 0..9, plus
//     the blank and dash patterns.
//   - State encoding of the serial conversion FSM.
// -----------------------------------------------------------------------------
package bcd_seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
// Combinational decoder from one BCD nibble to an active-low 7-segment
// pattern. Codes A..F are not valid BCD and show a dash (only g lit).
// Ports:
//   bcd  in  4  BCD digit
//   seg  out 7  active-low segments, bit0=a .. bit6=g
// -----------------------------------------------------------------------------
module bcd_to_seg7
  import bcd_seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg7_display.sv
// -----------------------------------------------------------------------------
// bcd_seg7_display
// Accepts a packed BCD word over valid/ready, converts it one digit per clock
// (most significant first) through a single shared decoder, then commits all
// digits to the display at once. Optional leading-zero blanking and a
// free-running blink mask are applied on the registered segment outputs.
// Ports:
//   i_clk       in  1             system clock
//   i_rst_n     in  1             asynchronous active-low reset
//   i_digits    in  4*NUM_DIGITS  packed BCD, [3:0] = units
//   i_valid     in  1             word valid
//   o_ready     out 1             idle, word can be accepted
//   i_blank_lz  in  1             blank leading zeros (sampled at handshake)
//   i_blink_en  in  1             enable blink masking
//   o_seg       out 7*NUM_DIGITS  active-low segments, [6:0] = units
//   o_done      out 1             one-cycle pulse when o_seg takes a new word
// Build option BCD_SEG7_DP_EN adds i_dp / o_dp (decimal points, o_dp
// active-low), captured and committed alongside the digits.
// -----------------------------------------------------------------------------
module bcd_seg7_display
  import bcd_seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_blank_lz,
  input  logic                    i_blink_en,
  output logic [7*NUM_DIGITS-1:0] o_seg,
`ifdef BCD_SEG7_DP_EN
  input  logic [NUM_DIGITS-1:0]   i_dp,
  output logic [NUM_DIGITS-1:0]   o_dp,
`endif
  output logic                    o_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(BLINK_DIV);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  state_t                     state_reg, state_next;
  logic [IDX_W-1:0]           idx_reg, idx_next;
  logic                       lz_reg, lz_next;
  logic [NUM_DIGITS-1:0][3:0] shadow_reg;
  logic [NUM_DIGITS-1:0][6:0] staging_reg, staging_next;
  logic [NUM_DIGITS-1:0][6:0] display_reg, display_next;
  logic [7*NUM_DIGITS-1:0]    seg_reg, seg_next;
  logic                       done_reg;
  logic                       capture, commit;
  logic [3:0]                 cur_digit;
  logic [6:0]                 cur_seg;
  logic [CNT_W-1:0]           cnt_reg, cnt_next;
  logic                       blank_reg, blank_next;   // 1 = blink phase blank

`ifdef BCD_SEG7_DP_EN
  logic [NUM_DIGITS-1:0] dp_shadow_reg;
  logic [NUM_DIGITS-1:0] dp_stage_reg, dp_stage_next;  // active-low
  logic [NUM_DIGITS-1:0] dp_disp_reg, dp_disp_next;
  logic [NUM_DIGITS-1:0] dp_out_reg;
`endif

  // One decoder serves every digit; the FSM steps idx across the word.
  assign cur_digit = shadow_reg[idx_reg];

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

  // ---------------- FSM state register ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      lz_reg      <= 1'b0;
      staging_reg <= '0;
`ifdef BCD_SEG7_DP_EN
      dp_stage_reg <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      lz_reg      <= lz_next;
      staging_reg <= staging_next;
`ifdef BCD_SEG7_DP_EN
      dp_stage_reg <= dp_stage_next;
`endif
    end
  end

  // ---------------- FSM next state / outputs ----------------
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    lz_next      = lz_reg;
    staging_next = staging_reg;
`ifdef BCD_SEG7_DP_EN
    dp_stage_next = dp_stage_reg;
`endif
    o_ready = 1'b0;
    capture = 1'b0;
    commit  = 1'b0;
    case (state_reg)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          capture    = 1'b1;
          idx_next   = IDX_MAX;
          lz_next    = i_blank_lz;
          state_next = CONV;
        end
      end
      CONV: begin
        // The units position (idx 0) is never blanked so zero reads "0".
        if (lz_reg && (cur_digit == 4'd0) && (idx_reg != '0)) begin
          staging_next[idx_reg] = SEG_BLANK;
`ifdef BCD_SEG7_DP_EN
          dp_stage_next[idx_reg] = 1'b1;
`endif
        end else begin
          staging_next[idx_reg] = cur_seg;
          lz_next               = 1'b0;
`ifdef BCD_SEG7_DP_EN
          dp_stage_next[idx_reg] = ~dp_shadow_reg[idx_reg];
`endif
        end
        if (idx_reg == '0) state_next = COMMIT;
        else               idx_next   = idx_reg - 1'b1;
      end
      COMMIT: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- Shadow capture at handshake ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow_reg <= '0;
`ifdef BCD_SEG7_DP_EN
      dp_shadow_reg <= '0;
`endif
    end else if (capture) begin
      shadow_reg <= i_digits;
`ifdef BCD_SEG7_DP_EN
      dp_shadow_reg <= i_dp;
`endif
    end
  end

  // ---------------- Blink prescaler ----------------
  always_comb begin
    cnt_next   = '0;
    blank_next = 1'b0;
    if (i_blink_en) begin
      if (cnt_reg == CNT_MAX) begin
        cnt_next   = '0;
        blank_next = ~blank_reg;
      end else begin
        cnt_next   = cnt_reg + 1'b1;
        blank_next = blank_reg;
      end
    end
  end

  // ---------------- Display and output registers ----------------
  // The mask uses the next blink phase and the next display contents so a
  // commit or an i_blink_en drop shows on the very edge it happens.
  assign display_next = commit ? staging_reg : display_reg;
`ifdef BCD_SEG7_DP_EN
  assign dp_disp_next = commit ? dp_stage_reg : dp_disp_reg;
`endif

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_mask
    assign seg_next[7*gi +: 7] = blank_next ? SEG_BLANK : display_next[gi];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_reg     <= '0;
      blank_reg   <= 1'b0;
      display_reg <= {NUM_DIGITS{SEG_BLANK}};
      seg_reg     <= '1;
      done_reg    <= 1'b0;
`ifdef BCD_SEG7_DP_EN
      dp_disp_reg <= '1;
      dp_out_reg  <= '1;
`endif
    end else begin
      cnt_reg     <= cnt_next;
      blank_reg   <= blank_next;
      display_reg <= display_next;
      seg_reg     <= seg_next;
      done_reg    <= commit;
`ifdef BCD_SEG7_DP_EN
      dp_disp_reg <= dp_disp_next;
      dp_out_reg  <= blank_next ? '1 : dp_disp_next;
`endif
    end
  end

  assign o_seg  = seg_reg;
  assign o_done = done_reg;
`ifdef BCD_SEG7_DP_EN
  assign o_dp   = dp_out_reg;
`endif

endmodule
